// File: rtl/ysyx_22040750_lsu_bus_ctrl_pkg.sv
// LSU bus controller shared types: FSM states, load funct3 codes, bus response codes.
// No ports; imported by ysyx_22040750_lsu_bus_ctrl and ysyx_22040750_load_ext.
package ysyx_22040750_lsu_bus_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_WB,
    ST_RD,
    ST_RR
  } state_e;

  localparam logic [2:0] LD_LB  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LW  = 3'b010;
  localparam logic [2:0] LD_LD  = 3'b011;
  localparam logic [2:0] LD_LBU = 3'b100;
  localparam logic [2:0] LD_LHU = 3'b101;
  localparam logic [2:0] LD_LWU = 3'b110;

  localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/ysyx_22040750_lsu_bus_ctrl_load_ext.sv
// Load extractor: shifts the 64-bit read beat by the byte offset, then sign/zero-extends.
// Ports: rdata (beat), off (addr[2:0]), ld_type (funct3) -> ld_data.
module ysyx_22040750_load_ext
  import ysyx_22040750_lsu_bus_ctrl_pkg::*;
(
  input  logic [63:0] rdata,
  input  logic [2:0]  off,
  input  logic [2:0]  ld_type,
  output logic [63:0] ld_data
);

  logic [63:0] sh;

  always_comb begin
    sh      = rdata >> {off, 3'b000};
    ld_data = '0;
    unique case (ld_type)
      LD_LB:  ld_data = {{56{sh[7]}}, sh[7:0]};
      LD_LH:  ld_data = {{48{sh[15]}}, sh[15:0]};
      LD_LW:  ld_data = {{32{sh[31]}}, sh[31:0]};
      LD_LD:  ld_data = sh;
      LD_LBU: ld_data = {56'd0, sh[7:0]};
      LD_LHU: ld_data = {48'd0, sh[15:0]};
      LD_LWU: ld_data = {32'd0, sh[31:0]};
      default: ld_data = '0;
    endcase
  end

endmodule

// File: rtl/ysyx_22040750_lsu_bus_ctrl.sv
// MEM-stage load/store controller: one single-beat AXI4-Lite-style access per request,
// ports: MEM req/done/stall, AW/W/B/AR/R channels. Option: YSYX_22040750_LSU_MISALIGN_CHK_EN.
module ysyx_22040750_lsu_bus_ctrl
  import ysyx_22040750_lsu_bus_ctrl_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              I_sys_clk,
  input  logic              I_rst,
  input  logic              I_req_valid,
  output logic              O_req_ready,
  input  logic              I_req_wr,
  input  logic [ADDR_W-1:0] I_addr,
  input  logic [DATA_W-1:0] I_wr_data,
  input  logic [7:0]        I_wr_strb,
  input  logic [2:0]        I_ld_type,
  output logic              O_done,
  output logic [63:0]       O_ld_data,
  output logic              O_bus_err,
  output logic              O_stall,
  output logic              O_awvalid,
  input  logic              I_awready,
  output logic [ADDR_W-1:0] O_awaddr,
  output logic              O_wvalid,
  input  logic              I_wready,
  output logic [DATA_W-1:0] O_wdata,
  output logic [7:0]        O_wstrb,
  input  logic              I_bvalid,
  output logic              O_bready,
  input  logic [1:0]        I_bresp,
  output logic              O_arvalid,
  input  logic              I_arready,
  output logic [ADDR_W-1:0] O_araddr,
  input  logic              I_rvalid,
  output logic              O_rready,
  input  logic [DATA_W-1:0] I_rdata,
  input  logic [1:0]        I_rresp
);

  state_e state_q, state_d;

  logic [ADDR_W-1:3] addr_q;
  logic [2:0]        off_q;
  logic [2:0]        ld_type_q;
  logic [DATA_W-1:0] wdata_q;
  logic [7:0]        wstrb_q;
  logic              awvalid_q, wvalid_q, arvalid_q;
  logic              done_q, err_q;
  logic [63:0]       ld_data_q;
  logic [63:0]       ext;

  logic idle, accept, mis;
  logic aw_hs, w_hs, aw_ok, w_ok, b_hs, r_hs;

  assign idle   = state_q == ST_IDLE;
  // The done cycle is also IDLE; blocking accept there keeps ops one apart.
  assign O_req_ready = idle & ~done_q;
  assign accept = I_req_valid & O_req_ready;

  assign aw_hs = awvalid_q & I_awready;
  assign w_hs  = wvalid_q & I_wready;
  // A channel is finished if it handshakes now or already did.
  assign aw_ok = aw_hs | ~awvalid_q;
  assign w_ok  = w_hs | ~wvalid_q;
  assign b_hs  = (state_q == ST_WB) & I_bvalid;
  assign r_hs  = (state_q == ST_RR) & I_rvalid;

`ifdef YSYX_22040750_LSU_MISALIGN_CHK_EN
  always_comb begin
    mis = 1'b0;
    if (|I_wr_strb[7:4])      mis = |I_addr[2:0];
    else if (|I_wr_strb[3:2]) mis = |I_addr[1:0];
    else if (I_wr_strb[1])    mis = I_addr[0];
  end
`else
  assign mis = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept && !mis) state_d = I_req_wr ? ST_WR : ST_RD;
      ST_WR:   if (aw_ok && w_ok) state_d = ST_WB;
      ST_WB:   if (I_bvalid) state_d = ST_IDLE;
      ST_RD:   if (I_arready) state_d = ST_RR;
      ST_RR:   if (I_rvalid) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  ysyx_22040750_load_ext u_load_ext (
    .rdata   (I_rdata[63:0]),
    .off     (off_q),
    .ld_type (ld_type_q),
    .ld_data (ext)
  );

  always_ff @(posedge I_sys_clk) begin
    if (I_rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      off_q     <= '0;
      ld_type_q <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      ld_data_q <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      if (accept) begin
        addr_q    <= I_addr[ADDR_W-1:3];
        off_q     <= I_addr[2:0];
        ld_type_q <= I_ld_type;
        wdata_q   <= I_wr_data;
        wstrb_q   <= I_wr_strb << I_addr[2:0];
        awvalid_q <= I_req_wr & ~mis;
        wvalid_q  <= I_req_wr & ~mis;
        arvalid_q <= ~I_req_wr & ~mis;
        if (mis) begin
          done_q    <= 1'b1;
          err_q     <= 1'b1;
          ld_data_q <= '0;
        end
      end
      if (aw_hs) awvalid_q <= 1'b0;
      if (w_hs)  wvalid_q  <= 1'b0;
      if (arvalid_q && I_arready) arvalid_q <= 1'b0;
      if (b_hs) begin
        done_q <= 1'b1;
        err_q  <= I_bresp != RESP_OKAY;
      end
      if (r_hs) begin
        done_q    <= 1'b1;
        err_q     <= I_rresp != RESP_OKAY;
        ld_data_q <= ext;
      end
    end
  end

  assign O_done    = done_q;
  assign O_bus_err = err_q;
  assign O_ld_data = ld_data_q;
  assign O_awvalid = awvalid_q;
  assign O_wvalid  = wvalid_q;
  assign O_arvalid = arvalid_q;
  assign O_awaddr  = {addr_q, 3'b000};
  assign O_araddr  = {addr_q, 3'b000};
  assign O_wdata   = wdata_q;
  assign O_wstrb   = wstrb_q;
  assign O_bready  = state_q == ST_WB;
  assign O_rready  = state_q == ST_RR;
  assign O_stall   = (I_req_valid & ~O_req_ready) | accept | ~idle;

endmodule

// File: doc/ysyx_22040750_lsu_bus_ctrl.md
Name: ysyx_22040750_lsu_bus_ctrl

Overview:
- Memory-stage load/store bus controller, directly downstream of the store-data replicator.
- Accepts one load or store per request from the MEM stage: byte-replicated store data plus a low-aligned byte mask.
- Shifts the mask to the access address, runs a single-beat AXI4-Lite-style transaction on the data bus and stalls the pipeline until the response returns.
- For loads, extracts the addressed byte/half/word/double from the 64-bit read beat and sign- or zero-extends it.

Parameters:
- ADDR_W, 64, address width.
- DATA_W, 64, data bus width; fixed at 64, other values unsupported.

Ports:
- I_sys_clk  in  1  clock.
- I_rst  in  1  synchronous active-high reset.
- I_req_valid  in  1  MEM stage presents a memory op.
- O_req_ready  out  1  controller idle; request accepted when valid&ready.
- I_req_wr  in  1  1=store, 0=load.
- I_addr  in  64  byte address.
- I_wr_data  in  64  store data, already replicated across lanes.
- I_wr_strb  in  8  low-aligned size mask: 0x01, 0x03, 0x0F or 0xFF.
- I_ld_type  in  3  funct3: 000 lb, 001 lh, 010 lw, 011 ld, 100 lbu, 101 lhu, 110 lwu.
- O_done  out  1  one-cycle completion pulse.
- O_ld_data  out  64  extended load result, valid with O_done on loads.
- O_bus_err  out  1  with O_done; response code was nonzero.
- O_stall  out  1  pipeline hold: (I_req_valid & ~O_req_ready) | (accept cycle) | (not IDLE and not completing).
- Bus AW channel: O_awvalid out 1, I_awready in 1, O_awaddr out 64.
- Bus W channel: O_wvalid out 1, I_wready in 1, O_wdata out 64, O_wstrb out 8.
- Bus B channel: I_bvalid in 1, O_bready out 1, I_bresp in 2.
- Bus AR channel: O_arvalid out 1, I_arready in 1, O_araddr out 64.
- Bus R channel: I_rvalid in 1, O_rready out 1, I_rdata in 64, I_rresp in 2.

Behaviour:
- Single clock I_sys_clk; I_rst synchronous, active-high.
- Reset values: all valids/readys 0, O_done 0, O_bus_err 0, O_ld_data 0, O_req_ready 1, state IDLE.
- On accept, register addr, data, ld_type, wr. O_wstrb = I_wr_strb << I_addr[2:0], truncated to 8 bits.
- AW/AR address: O_awaddr/O_araddr = I_addr with [2:0] cleared.
- States and transitions:
  - IDLE: accept store -> WR; accept load -> RD.
  - WR: O_awvalid and O_wvalid asserted. Each is dropped independently after its own handshake; both may complete in the same cycle or in either order. Both done -> WB.
  - WB: O_bready=1. On I_bvalid: O_done pulse, O_bus_err=|I_bresp; -> IDLE.
  - RD: O_arvalid until I_arready -> RR.
  - RR: O_rready=1. On I_rvalid: O_done pulse, O_ld_data registered, O_bus_err=|I_rresp; -> IDLE.
- Valids are registered. Once asserted, a valid and its payload stay stable until handshake. No valid depends combinationally on a ready.
- Latency: accept at edge N puts valids high from cycle N+1. Minimum op is 3 cycles from accept to O_done, with zero-wait slave.
- O_req_ready is high only in IDLE, so there is no back-to-back accept in the O_done cycle. The next accept can occur the cycle after O_done.
- Load extract: sh = I_rdata >> (8*addr[2:0]). Low 8/16/32/64 bits per ld_type; sign-extend for 000/001/010, zero-extend for 1xx. ld_type 111 gives 0.
- Write-response/read data arriving without an outstanding op is ignored, because bready/rready are 0.
- Reset mid-transaction: next edge returns to IDLE and drops all valids. The pipeline is flushed alongside it.

Optional Feature:
- Macro YSYX_22040750_LSU_MISALIGN_CHK_EN.
- Defined: at accept, when addr is not aligned to the access size (mask-derived: half addr[0], word addr[1:0], double addr[2:0] nonzero), go to IDLE. No bus valid is issued, O_done and O_bus_err are pulsed the next cycle, and O_ld_data=0.
- Undefined: no check. A misaligned access is issued and its mask truncates at the 8-byte boundary.

Decomposition:
- Shared package/header: state encodings (IDLE, WR, WB, RD, RR), ld_type constants, the RESP_OKAY=2'b00 constant.
- One sub-module: ysyx_22040750_load_ext, combinational, taking (rdata, addr[2:0], ld_type) and producing ld_data. FSM and channel logic stay in the top.

Test Plan:
- sd at 0x8000_0010, data 0x1122334455667788, strb 0xFF, zero-wait slave -> O_wstrb 0xFF, O_awaddr 0x8000_0010, O_done 3 cycles after accept, O_bus_err 0.
- sb at 0x8000_0005, data 0xABABABABABABABAB, strb 0x01; wready arriving 2 cycles before awready -> O_wstrb 0x20; WB entered only after both handshakes; single O_done.
- lh at 0x...06 with rdata 0x8001_0000_0000_0000 -> O_ld_data 0xFFFF_FFFF_FFFF_8001. lhu same -> 0x0000_0000_0000_8001.
- lw at 0x...04, rdata 0x7FFF_FFFF_0000_0000, arready delayed 4 cycles -> arvalid held steady 4 cycles, O_stall high throughout, O_ld_data 0x7FFF_FFFF.
- Store with bresp=2'b10 -> O_done with O_bus_err=1. With the macro defined, lw at 0x...02 issues no arvalid, and O_done+O_bus_err pulse one cycle after accept.
- I_rst asserted while in RR with rvalid low -> next cycle O_req_ready=1, all valids/readys 0, no O_done.
